// File: rtl/xosera_bus_if_if.sv
// m68k-side bus signal bundle for the Xosera bus interface.
// The host drives strobes/address/data; the slave returns read data and DTACK.
`timescale 1ns/1ps
interface xosera_bus_if_if;
  logic       bus_cs_n_i;
  logic       bus_rd_nwr_i;
  logic       bus_bytesel_i;
  logic [3:0] bus_reg_num_i;
  logic [7:0] bus_data_i;
  logic [7:0] bus_data_o;
  logic       bus_dtack_o;

  modport master (
    output bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i,
    input  bus_data_o, bus_dtack_o
  );

  modport slave (
    input  bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i,
    output bus_data_o, bus_dtack_o
  );
endinterface

// File: rtl/xosera_bus_if.sv
// Asynchronous m68k bus to pixel-clock core bridge: synchronizes CS, issues one
// read/write strobe per CS assertion and generates a delayed, held DTACK.
`timescale 1ns/1ps
module xosera_bus_if #(
  parameter int SYNC_STAGES = 2,
  parameter int DTACK_DELAY = 2
) (
  input  logic             clk,
  input  logic             reset_n_i,
  xosera_bus_if_if.slave   bus,
  input  logic [7:0]       rd_data_i,
  output logic             write_strobe_o,
  output logic             read_strobe_o,
  output logic [3:0]       reg_num_o,
  output logic             bytesel_o,
  output logic [7:0]       data_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   cs_sync_s;
  logic                   primed_s;
  logic                   start_s;

  logic       armed_q,    armed_d;
  logic       rd_nwr_q,   rd_nwr_d;
  logic [3:0] reg_num_q,  reg_num_d;
  logic       bytesel_q,  bytesel_d;
  logic [7:0] data_q,     data_d;
  logic [7:0] bus_data_q, bus_data_d;
  logic       dtack_q,    dtack_d;
  logic       wstb_q,     wstb_d;
  logic       rstb_q,     rstb_d;
  logic [3:0] cnt_q,      cnt_d;

  // prime_q marks when cs_sync reflects real samples rather than reset values,
  // so CS held low across reset cannot be mistaken for a fresh high-to-low edge.
  assign cs_sync_s = sync_q[SYNC_STAGES-1];
  assign primed_s  = prime_q[SYNC_STAGES-1];
  assign start_s   = (state_q == IDLE) && armed_q && !cs_sync_s;

  // CS synchronizer and post-reset priming shift register
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q  <= {SYNC_STAGES{1'b1}};
      prime_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.bus_cs_n_i};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      rd_nwr_q   <= 1'b0;
      reg_num_q  <= 4'd0;
      bytesel_q  <= 1'b0;
      data_q     <= 8'd0;
      bus_data_q <= 8'd0;
      dtack_q    <= 1'b1;
      wstb_q     <= 1'b0;
      rstb_q     <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      rd_nwr_q   <= rd_nwr_d;
      reg_num_q  <= reg_num_d;
      bytesel_q  <= bytesel_d;
      data_q     <= data_d;
      bus_data_q <= bus_data_d;
      dtack_q    <= dtack_d;
      wstb_q     <= wstb_d;
      rstb_q     <= rstb_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic; a released CS always wins over the counter reaching zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_s) state_d = STROBE;
        else         state_d = IDLE;
      end
      STROBE: begin
        if (cs_sync_s) state_d = IDLE;
        else           state_d = WAIT;
      end
      WAIT: begin
        if (cs_sync_s)           state_d = IDLE;
        else if (cnt_q == 4'd0)  state_d = HOLD;
        else                     state_d = WAIT;
      end
      HOLD: begin
        if (cs_sync_s) state_d = IDLE;
        else           state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    armed_d    = armed_q;
    rd_nwr_d   = rd_nwr_q;
    reg_num_d  = reg_num_q;
    bytesel_d  = bytesel_q;
    data_d     = data_q;
    bus_data_d = bus_data_q;
    dtack_d    = dtack_q;
    wstb_d     = 1'b0;
    rstb_d     = 1'b0;
    cnt_d      = cnt_q;

    if (primed_s && cs_sync_s) armed_d = 1'b1;
    else if (start_s)          armed_d = 1'b0;
    else                       armed_d = armed_q;

    case (state_q)
      IDLE: begin
        if (start_s) begin
          rd_nwr_d  = bus.bus_rd_nwr_i;
          reg_num_d = bus.bus_reg_num_i;
          bytesel_d = bus.bus_bytesel_i;
          data_d    = bus.bus_data_i;
          wstb_d    = ~bus.bus_rd_nwr_i;
          rstb_d    = bus.bus_rd_nwr_i;
        end else begin
          wstb_d = 1'b0;
          rstb_d = 1'b0;
        end
      end
      STROBE: begin
        cnt_d = 4'(DTACK_DELAY);
        if (rd_nwr_q) bus_data_d = rd_data_i;
        else          bus_data_d = bus_data_q;
      end
      WAIT: begin
        if (cs_sync_s)          cnt_d   = cnt_q;
        else if (cnt_q == 4'd0) dtack_d = 1'b0;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      HOLD: begin
        if (cs_sync_s) dtack_d = 1'b1;
        else           dtack_d = 1'b0;
      end
      default: begin
        dtack_d = 1'b1;
      end
    endcase
  end

  assign write_strobe_o  = wstb_q;
  assign read_strobe_o   = rstb_q;
  assign reg_num_o       = reg_num_q;
  assign bytesel_o       = bytesel_q;
  assign data_o          = data_q;
  assign bus.bus_data_o  = bus_data_q;
  assign bus.bus_dtack_o = dtack_q;

endmodule

// File: tb/tb_xosera_bus_if.sv
// Scoreboard bench: four DUTs (DTACK_DELAY 0/2/5/15) share one random bus stream;
// expected strobes and DTACK edges are computed per access from CS timing.
`timescale 1ns/1ps
module tb_xosera_bus_if;
  localparam int NI = 4;
  localparam int DLY_A [NI] = '{0, 2, 5, 15};
  localparam int SYN_A [NI] = '{2, 2, 3, 2};

  typedef struct packed {
    logic        rd;
    logic [3:0]  rn;
    logic        bs;
    logic [7:0]  dat;
    logic [31:0] cyc;
  } stb_t;

  typedef struct packed {
    logic        lvl;
    logic [31:0] cyc;
    logic [7:0]  bdat;
    logic        chk;
  } dtk_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       rd_nwr = 1'b0;
  logic       bsel = 1'b0;
  logic [3:0] rnum = 4'd0;
  logic [7:0] wdat = 8'd0;
  logic [7:0] regfile [32];

  logic [NI-1:0] ws, rs, dtk, bso;
  logic [7:0]    bdo [NI];
  logic [7:0]    dato [NI];
  logic [7:0]    rdd [NI];
  logic [3:0]    rno [NI];

  int unsigned cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  stb_t sq [NI][$];
  dtk_t dq [NI][$];
  logic [7:0] last_rd [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    xosera_bus_if_if bif ();
    assign bif.bus_cs_n_i    = cs_n;
    assign bif.bus_rd_nwr_i  = rd_nwr;
    assign bif.bus_bytesel_i = bsel;
    assign bif.bus_reg_num_i = rnum;
    assign bif.bus_data_i    = wdat;
    assign dtk[g] = bif.bus_dtack_o;
    assign bdo[g] = bif.bus_data_o;
    assign rdd[g] = regfile[{rno[g], bso[g]}];

    xosera_bus_if #(.SYNC_STAGES(SYN_A[g]), .DTACK_DELAY(DLY_A[g])) u_dut (
      .clk            (clk),
      .reset_n_i      (reset_n),
      .bus            (bif),
      .rd_data_i      (rdd[g]),
      .write_strobe_o (ws[g]),
      .read_strobe_o  (rs[g]),
      .reg_num_o      (rno[g]),
      .bytesel_o      (bso[g]),
      .data_o         (dato[g])
    );

    initial begin : mon
      logic prev;
      stb_t e;
      dtk_t d;
      prev = 1'b1;
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          prev = dtk[g];
        end else begin
          if (ws[g] || rs[g]) begin
            vectors++;
            if (sq[g].size() == 0) begin
              miscompares++;
              $display("FAIL strobe[%0d] cyc %0d: got w=%b r=%b, required no strobe", g, cyc, ws[g], rs[g]);
            end else begin
              e = sq[g].pop_front();
              if (ws[g] == e.rd || rs[g] != e.rd || rno[g] != e.rn || bso[g] != e.bs
                  || dato[g] != e.dat || cyc != e.cyc) begin
                miscompares++;
                $display("FAIL strobe[%0d]: got cyc=%0d w=%b r=%b reg=%h bs=%b dat=%h, required cyc=%0d rd=%b reg=%h bs=%b dat=%h",
                         g, cyc, ws[g], rs[g], rno[g], bso[g], dato[g], e.cyc, e.rd, e.rn, e.bs, e.dat);
              end
            end
          end
          if (dtk[g] != prev) begin
            vectors++;
            if (dq[g].size() == 0) begin
              miscompares++;
              $display("FAIL dtack[%0d] cyc %0d: got edge to %b, required no edge", g, cyc, dtk[g]);
            end else begin
              d = dq[g].pop_front();
              if (dtk[g] != d.lvl || cyc != d.cyc || (d.chk && bdo[g] != d.bdat)) begin
                miscompares++;
                $display("FAIL dtack[%0d]: got lvl=%b cyc=%0d bus_data=%h, required lvl=%b cyc=%0d bus_data=%h",
                         g, dtk[g], cyc, bdo[g], d.lvl, d.cyc, d.bdat);
              end
            end
          end
          prev = dtk[g];
        end
      end
    end
  end

  // Reference: strobe at T0+SYNC; DTACK falls at strobe+DELAY+2 only if CS stays
  // low for at least DELAY+3 clocks, and rises SYNC clocks after CS returns high.
  task automatic start_access(input logic rd, input logic [3:0] rn, input logic bs,
                              input logic [7:0] dat, input int len);
    int t0;
    int e0;
    rd_nwr = rd; rnum = rn; bsel = bs; wdat = dat; cs_n = 1'b0;
    t0 = int'(cyc) + 1;
    for (int i = 0; i < NI; i++) begin
      e0 = t0 + SYN_A[i];
      sq[i].push_back('{rd, rn, bs, dat, 32'(e0)});
      if (rd) last_rd[i] = regfile[{rn, bs}];
      if (len >= DLY_A[i] + 3) begin
        dq[i].push_back('{1'b0, 32'(e0 + DLY_A[i] + 2), last_rd[i], 1'b1});
        dq[i].push_back('{1'b1, 32'(t0 + len + SYN_A[i]), 8'd0, 1'b0});
      end
    end
  endtask

  task automatic do_access(input logic rd, input logic [3:0] rn, input logic bs,
                           input logic [7:0] dat, input int len, input int hi);
    @(negedge clk);
    start_access(rd, rn, bs, dat, len);
    repeat (len) @(negedge clk);
    cs_n = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (dtk[i] !== 1'b1 || ws[i] !== 1'b0 || rs[i] !== 1'b0 || bdo[i] !== 8'd0
          || dato[i] !== 8'd0 || rno[i] !== 4'd0 || bso[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s[%0d]: got dtack=%b w=%b r=%b bus_data=%h data=%h reg=%h bs=%b, required 1/0/0/00/00/0/0",
                 tag, i, dtk[i], ws[i], rs[i], bdo[i], dato[i], rno[i], bso[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = 8'($urandom);
    regfile[{4'h2, 1'b0}] = 8'h3C;
    for (int i = 0; i < NI; i++) last_rd[i] = 8'd0;

    repeat (3) @(negedge clk);
    check_reset_state("reset_init");
    #1 reset_n = 1'b1;
    repeat (6) @(negedge clk);

    do_access(1'b0, 4'h5, 1'b1, 8'hA7, 30, 8);
    do_access(1'b1, 4'h2, 1'b0, 8'h55, 30, 8);
    do_access(1'b0, 4'h9, 1'b0, 8'h11, 30, 8);
    do_access(1'b0, 4'h3, 1'b1, 8'h42, 200, 8);
    foreach (DLY_A[i]) begin
      do_access(1'b1, 4'(i), 1'b1, 8'(i), DLY_A[i] + 2, 5);
      do_access(1'b1, 4'(i + 4), 1'b0, 8'(i), DLY_A[i] + 3, 5);
    end
    do_access(1'b0, 4'h6, 1'b0, 8'h77, 1, 4);
    repeat (40) begin
      do_access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                8'($urandom), $urandom_range(1, 25), $urandom_range(3, 8));
    end

    @(negedge clk);
    start_access(1'b0, 4'h7, 1'b1, 8'hC3, 1000);
    repeat (30) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_reset_state("reset_hold");
    @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      sq[i].delete();
      dq[i].delete();
      last_rd[i] = 8'd0;
    end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    do_access(1'b1, 4'h2, 1'b0, 8'h00, 30, 8);
    repeat (8) begin
      do_access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                8'($urandom), $urandom_range(1, 25), $urandom_range(3, 8));
    end

    repeat (40) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (sq[i].size() != 0 || dq[i].size() != 0) begin
        miscompares++;
        $display("FAIL drain[%0d]: got %0d strobes and %0d dtack edges outstanding, required 0 and 0",
                 i, sq[i].size(), dq[i].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/xosera_bus_if.md
XOSERA_BUS_IF -- requirements
Module: xosera_bus_if

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on bus_cs_n_i; legal range 2..3.
REQ-002 The block SHALL have parameter DTACK_DELAY, default 2, meaning the extra clocks between the access strobe and DTACK assertion; legal range 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single pixel clock; all flops use its rising edge.
REQ-004 The block SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port bus_cs_n_i, input, 1 bit: m68k chip select, asynchronous, active-low.
REQ-006 The block SHALL have port bus_rd_nwr_i, input, 1 bit: 1 = read, 0 = write; asynchronous.
REQ-007 The block SHALL have port bus_bytesel_i, input, 1 bit: byte select; asynchronous.
REQ-008 The block SHALL have port bus_reg_num_i, input, 4 bits: register number; asynchronous.
REQ-009 The block SHALL have port bus_data_i, input, 8 bits: write data from the bus; asynchronous.
REQ-010 The block SHALL have port bus_data_o, output, 8 bits: registered read data toward the tri-state pad.
REQ-011 The block SHALL have port bus_dtack_o, output, 1 bit: DTACK level, active-low, driven straight to the pin.
REQ-012 The block SHALL have port rd_data_i, input, 8 bits: register-file read data, combinational from reg_num_o and bytesel_o.
REQ-013 The block SHALL have port write_strobe_o, output, 1 bit: one-clock write request to the core.
REQ-014 The block SHALL have port read_strobe_o, output, 1 bit: one-clock read request to the core.
REQ-015 The block SHALL have port reg_num_o, output, 4 bits: captured register number.
REQ-016 The block SHALL have port bytesel_o, output, 1 bit: captured byte select.
REQ-017 The block SHALL have port data_o, output, 8 bits: captured write data.

Function
REQ-018 The block SHALL pass bus_cs_n_i through SYNC_STAGES flops, reset to 1, to form cs_sync. All other bus inputs SHALL be sampled directly, because they are stable before CS falls.
REQ-019 The FSM SHALL have the states IDLE, STROBE, WAIT and HOLD, and SHALL reset to IDLE.
REQ-020 In IDLE, on the first edge that sees cs_sync = 0, the block SHALL capture rd_nwr, reg_num, bytesel and data into the output registers and enter STROBE.
REQ-021 In STROBE, the block SHALL assert exactly one of write_strobe_o / read_strobe_o, selected by the captured rd_nwr, for exactly 1 clock.
REQ-022 On the edge that leaves STROBE, the block SHALL load the 4-bit delay counter with DTACK_DELAY and enter WAIT.
REQ-023 On the edge that leaves STROBE, for a read only, the block SHALL also latch rd_data_i into bus_data_o.
REQ-024 In WAIT, the counter SHALL decrement by 1 per clock.
REQ-025 On the edge where WAIT sees the counter = 0, the block SHALL drive bus_dtack_o to 0 and enter HOLD.
REQ-026 Net DTACK timing SHALL be: bus_dtack_o falls exactly DTACK_DELAY+2 edges after the edge that asserts the strobe.
REQ-027 In HOLD, bus_dtack_o SHALL stay 0 until cs_sync = 1. On that edge, bus_dtack_o SHALL return to 1 and the FSM SHALL return to IDLE.
REQ-028 Abort in STROBE (cs_sync = 1 while in STROBE): the strobe SHALL still complete, and the FSM SHALL go to IDLE with no DTACK.
REQ-029 Abort in WAIT (cs_sync = 1 while in WAIT): the FSM SHALL go to IDLE with no DTACK.
REQ-030 A new access SHALL require cs_sync = 1 to be observed in IDLE first. Holding CS low after HOLD exits is impossible by construction, so at most one strobe SHALL issue per CS assertion.
REQ-031 reg_num_o, bytesel_o and data_o SHALL hold until the next capture.
REQ-032 bus_data_o SHALL hold until the next read latch; write accesses SHALL NOT alter it.
REQ-033 The delay counter SHALL NOT wrap. It is loaded only from DTACK_DELAY and stops at 0.

Reset
REQ-034 Asserting reset_n_i = 0 SHALL, immediately and without a clock, force:
- FSM to IDLE
- synchronizer flops to 1
- bus_dtack_o = 1
- both strobes = 0
- bus_data_o, data_o, reg_num_o, bytesel_o and the counter = 0
REQ-035 Reset asserted mid-access, including in HOLD, SHALL release DTACK at once.
REQ-036 After reset deasserts with CS still low, the block SHALL NOT start an access until CS has gone high and low again.

Verification
REQ-037 Write scenario, defaults: CS low with rd_nwr=0, reg=0x5, bytesel=1, data=0xA7 -> write_strobe_o high for 1 clock, with reg_num_o=0x5, bytesel_o=1, data_o=0xA7. bus_dtack_o SHALL fall 4 edges after the strobe edge and rise 1 edge after cs_sync returns to 1.
REQ-038 Read scenario: rd_data_i=0x3C, read of reg 0x2 -> read_strobe_o high for 1 clock, and bus_data_o=0x3C before bus_dtack_o falls. A following write SHALL leave bus_data_o at 0x3C.
REQ-039 Aborts: CS released during WAIT (DTACK_DELAY=5) -> one strobe issued, no DTACK, FSM in IDLE; the next access behaves normally.
REQ-040 CS held low for 200 clocks -> exactly one strobe, and DTACK stays low until CS rises.
REQ-041 Reset pulse while in HOLD -> bus_dtack_o=1 within the same cycle, and no new strobe until CS toggles high then low.
REQ-042 DTACK_DELAY=0 and DTACK_DELAY=15 -> DTACK falls 2 and 17 edges after the strobe edge respectively.
